operand_fetch_stage: RTL and testbench

Decode-to-execute stage sitting directly in front of the 16x32 register file. It drives the register file read addresses and captures the returned operands. A 16-entry scoreboard blocks RAW and WAW hazards. Writeback data is bypassed in the same cycle, and operands are handed to execute over a valid/ready pipeline register.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/operand_fetch_stage_if.sv | 54 +++++
 rtl/operand_fetch_stage_scoreboard.sv | 42 ++++
 rtl/operand_fetch_stage.sv | 92 +++++++++
 tb/tb_operand_fetch_stage.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the operand fetch stage.
package cpu_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH  = 4;
    localparam int NUM_REGS        = 2 ** REG_ADDR_WIDTH;
    localparam int CTRL_WIDTH      = 8;
    localparam int STALL_CNT_WIDTH = 16;

    typedef logic [REG_ADDR_WIDTH-1:0]  reg_addr_t;
    typedef logic [DATA_WIDTH-1:0]      word_t;
    typedef logic [CTRL_WIDTH-1:0]      ctrl_t;
    typedef logic [NUM_REGS-1:0]        reg_mask_t;
    typedef logic [STALL_CNT_WIDTH-1:0] stall_cnt_t;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decode, register-file, writeback and execute signals of the operand fetch stage.
interface operand_fetch_stage_if;
    import cpu_pkg::*;

    logic       id_valid;
    logic       id_ready;
    reg_addr_t  id_src1;
    reg_addr_t  id_src2;
    reg_addr_t  id_dest;
    logic       id_reg_write;
    ctrl_t      id_ctrl;

    reg_addr_t  rf_read_reg1;
    reg_addr_t  rf_read_reg2;
    word_t      rf_read_data1;
    word_t      rf_read_data2;

    logic       wb_valid;
    reg_addr_t  wb_reg;
    word_t      wb_data;

    logic       ex_valid;
    logic       ex_ready;
    word_t      ex_op1;
    word_t      ex_op2;
    reg_addr_t  ex_dest;
    logic       ex_reg_write;
    ctrl_t      ex_ctrl;

    reg_mask_t  pending;
    stall_cnt_t stall_count;

    // Master: decode, register file, writeback and execute around the stage.
    modport master (
        output id_valid, id_src1, id_src2, id_dest, id_reg_write, id_ctrl,
        output rf_read_data1, rf_read_data2,
        output wb_valid, wb_reg, wb_data,
        output ex_ready,
        input  id_ready, rf_read_reg1, rf_read_reg2,
        input  ex_valid, ex_op1, ex_op2, ex_dest, ex_reg_write, ex_ctrl,
        input  pending, stall_count
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_dest, id_reg_write, id_ctrl,
        input  rf_read_data1, rf_read_data2,
        input  wb_valid, wb_reg, wb_data,
        input  ex_ready,
        output id_ready, rf_read_reg1, rf_read_reg2,
        output ex_valid, ex_op1, ex_op2, ex_dest, ex_reg_write, ex_ctrl,
        output pending, stall_count
    );

endinterface

// File: rtl/operand_fetch_stage_scoreboard.sv
// Pending-writer bitmap: one bit per register, set on issue, cleared on writeback.
module scoreboard
    import cpu_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                i_set_en,
    input  reg_addr_t           i_set_idx,
    input  logic                i_clr_en,
    input  reg_addr_t           i_clr_idx,
    input  reg_addr_t [2:0]     i_q_idx,
    output logic      [2:0]     o_busy,
    output reg_mask_t           o_pending
);

    reg_mask_t r_pending;
    reg_mask_t w_set_mask;
    reg_mask_t w_clr_mask;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en) w_set_mask[i_set_idx] = 1'b1;
        if (i_clr_en) w_clr_mask[i_clr_idx] = 1'b1;
    end

    // A writeback in flight this cycle already resolves the hazard.
    always_comb begin
        o_busy = '0;
        for (int q = 0; q < 3; q++)
            o_busy[q] = r_pending[i_q_idx[q]] && !(i_clr_en && i_clr_idx == i_q_idx[q]);
    end

    // Set is OR'd after clear so a new writer wins over a same-cycle writeback.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_pending <= '0;
        else       r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: hazard check, writeback bypass and valid/ready register to execute.
module operand_fetch_stage
    import cpu_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    operand_fetch_stage_if.slave  bus
);

    logic       r_ex_valid;
    word_t      r_ex_op1;
    word_t      r_ex_op2;
    reg_addr_t  r_ex_dest;
    logic       r_ex_reg_write;
    ctrl_t      r_ex_ctrl;
    stall_cnt_t r_stall_count;

    logic       [2:0] w_busy;
    reg_mask_t  w_pending;
    logic       w_slot_free;
    logic       w_hazard;
    logic       w_ready;
    logic       w_fire;
    logic       w_wb_hit1;
    logic       w_wb_hit2;
    word_t      w_op1;
    word_t      w_op2;

    scoreboard u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .i_set_en  (w_fire && bus.id_reg_write),
        .i_set_idx (bus.id_dest),
        .i_clr_en  (bus.wb_valid),
        .i_clr_idx (bus.wb_reg),
        .i_q_idx   ({bus.id_dest, bus.id_src2, bus.id_src1}),
        .o_busy    (w_busy),
        .o_pending (w_pending)
    );

    assign w_slot_free = !r_ex_valid || bus.ex_ready;
    assign w_hazard    = w_busy[0] || w_busy[1] || (bus.id_reg_write && w_busy[2]);
    assign w_ready     = w_slot_free && !w_hazard;
    assign w_fire      = bus.id_valid && w_ready;

    // The register file writes on the same edge, so its read port is stale for wb_reg.
    assign w_wb_hit1 = bus.wb_valid && bus.wb_reg == bus.id_src1;
    assign w_wb_hit2 = bus.wb_valid && bus.wb_reg == bus.id_src2;
    assign w_op1     = w_wb_hit1 ? bus.wb_data : bus.rf_read_data1;
    assign w_op2     = w_wb_hit2 ? bus.wb_data : bus.rf_read_data2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ex_valid     <= 1'b0;
            r_ex_op1       <= '0;
            r_ex_op2       <= '0;
            r_ex_dest      <= '0;
            r_ex_reg_write <= 1'b0;
            r_ex_ctrl      <= '0;
        end else if (w_fire) begin
            r_ex_valid     <= 1'b1;
            r_ex_op1       <= w_op1;
            r_ex_op2       <= w_op2;
            r_ex_dest      <= bus.id_dest;
            r_ex_reg_write <= bus.id_reg_write;
            r_ex_ctrl      <= bus.id_ctrl;
        end else if (bus.ex_ready) begin
            r_ex_valid     <= 1'b0;
        end
    end

    // Only hazard stalls count; backpressure stalls are excluded by slot_free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_stall_count <= '0;
        else if (bus.id_valid && w_slot_free && w_hazard && r_stall_count != '1)
            r_stall_count <= r_stall_count + 1'b1;
    end

    assign bus.id_ready     = w_ready;
    assign bus.rf_read_reg1 = bus.id_src1;
    assign bus.rf_read_reg2 = bus.id_src2;
    assign bus.ex_valid     = r_ex_valid;
    assign bus.ex_op1       = r_ex_op1;
    assign bus.ex_op2       = r_ex_op2;
    assign bus.ex_dest      = r_ex_dest;
    assign bus.ex_reg_write = r_ex_reg_write;
    assign bus.ex_ctrl      = r_ex_ctrl;
    assign bus.pending      = w_pending;
    assign bus.stall_count  = r_stall_count;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed-vector bench for operand_fetch_stage with hand-computed expectations.
module tb_operand_fetch_stage;
    import cpu_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    operand_fetch_stage_if bus ();

    operand_fetch_stage dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input reg_addr_t s1, input reg_addr_t s2, input reg_addr_t d,
                         input logic rw, input ctrl_t c, input word_t d1, input word_t d2);
        bus.id_valid      = 1'b1;
        bus.id_src1       = s1;
        bus.id_src2       = s2;
        bus.id_dest       = d;
        bus.id_reg_write  = rw;
        bus.id_ctrl       = c;
        bus.rf_read_data1 = d1;
        bus.rf_read_data2 = d2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.id_valid = 1'b0; bus.id_src1 = '0; bus.id_src2 = '0; bus.id_dest = '0;
        bus.id_reg_write = 1'b0; bus.id_ctrl = '0;
        bus.rf_read_data1 = '0; bus.rf_read_data2 = '0;
        bus.wb_valid = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
        bus.ex_ready = 1'b1;
        tick(); tick();

        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_pending",  32'(bus.pending), 32'h0);
        chk("rst_stall",    32'(bus.stall_count), 32'd0);
        chk("rst_ex_op1",   bus.ex_op1, 32'h0);
        chk("rst_id_ready", 32'(bus.id_ready), 32'd1);
        reset = 1'b0;
        tick();

        // Independent issue
        issue(4'd3, 4'd4, 4'd1, 1'b0, 8'hA5, 32'h11, 32'h22);
        #1;
        chk("rf_reg1", 32'(bus.rf_read_reg1), 32'd3);
        chk("rf_reg2", 32'(bus.rf_read_reg2), 32'd4);
        chk("ind_ready", 32'(bus.id_ready), 32'd1);
        tick();
        bus.id_valid = 1'b0;
        chk("ind_valid", 32'(bus.ex_valid), 32'd1);
        chk("ind_op1",   bus.ex_op1, 32'h11);
        chk("ind_op2",   bus.ex_op2, 32'h22);
        chk("ind_ctrl",  32'(bus.ex_ctrl), 32'hA5);
        chk("ind_dest",  32'(bus.ex_dest), 32'd1);
        chk("ind_rw",    32'(bus.ex_reg_write), 32'd0);
        chk("ind_pend",  32'(bus.pending), 32'h0);
        tick();
        chk("drain_valid", 32'(bus.ex_valid), 32'd0);
        chk("drain_stale", bus.ex_op1, 32'h11);

        // RAW hazard then writeback bypass
        issue(4'd0, 4'd0, 4'd5, 1'b1, 8'h01, 32'h100, 32'h200);
        tick();
        chk("raw_pend5", 32'(bus.pending), 32'h20);
        issue(4'd5, 4'd2, 4'd6, 1'b1, 8'h02, 32'h555, 32'h33);
        #1;
        chk("raw_block", 32'(bus.id_ready), 32'd0);
        chk("raw_st0",   32'(bus.stall_count), 32'd0);
        tick();
        chk("raw_st1",   32'(bus.stall_count), 32'd1);
        tick();
        chk("raw_st2",   32'(bus.stall_count), 32'd2);
        bus.wb_valid = 1'b1; bus.wb_reg = 4'd5; bus.wb_data = 32'hDEADBEEF;
        #1;
        chk("raw_wb_ready", 32'(bus.id_ready), 32'd1);
        tick();
        bus.id_valid = 1'b0; bus.wb_valid = 1'b0;
        chk("raw_op1",  bus.ex_op1, 32'hDEADBEEF);
        chk("raw_op2",  bus.ex_op2, 32'h33);
        chk("raw_pend", 32'(bus.pending), 32'h40);
        chk("raw_st_hold", 32'(bus.stall_count), 32'd2);
        bus.wb_valid = 1'b1; bus.wb_reg = 4'd6;
        tick();
        bus.wb_valid = 1'b0;
        chk("wb6_clear", 32'(bus.pending), 32'h0);

        // Backpressure
        bus.ex_ready = 1'b0;
        issue(4'd1, 4'd2, 4'd8, 1'b0, 8'h44, 32'hAAAA, 32'hBBBB);
        tick();
        chk("bp_valid", 32'(bus.ex_valid), 32'd1);
        issue(4'd9, 4'd10, 4'd11, 1'b0, 8'h55, 32'h1234, 32'h5678);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_block", 32'(bus.id_ready), 32'd0);
            tick();
            chk("bp_op1",   bus.ex_op1, 32'hAAAA);
            chk("bp_ctrl",  32'(bus.ex_ctrl), 32'h44);
            chk("bp_vld",   32'(bus.ex_valid), 32'd1);
            chk("bp_stall", 32'(bus.stall_count), 32'd2);
        end
        bus.ex_ready = 1'b1;
        #1;
        chk("bp_release", 32'(bus.id_ready), 32'd1);
        tick();
        bus.id_valid = 1'b0;
        chk("bp_op1_new", bus.ex_op1, 32'h1234);
        chk("bp_op2_new", bus.ex_op2, 32'h5678);
        chk("bp_ctrl_new", 32'(bus.ex_ctrl), 32'h55);
        tick();
        chk("bp_drain", 32'(bus.ex_valid), 32'd0);

        // Same-cycle set and clear on register 7
        issue(4'd0, 4'd0, 4'd7, 1'b1, 8'h07, 32'h0, 32'h0);
        tick();
        bus.id_valid = 1'b0;
        chk("sc_pend7", 32'(bus.pending), 32'h80);
        issue(4'd1, 4'd2, 4'd7, 1'b1, 8'h08, 32'h1, 32'h2);
        bus.wb_valid = 1'b1; bus.wb_reg = 4'd7; bus.wb_data = 32'h77;
        #1;
        chk("sc_ready", 32'(bus.id_ready), 32'd1);
        tick();
        bus.id_valid = 1'b0; bus.wb_valid = 1'b0;
        chk("sc_pend_kept", 32'(bus.pending), 32'h80);
        chk("sc_fired", 32'(bus.ex_ctrl), 32'h08);
        chk("sc_stall", 32'(bus.stall_count), 32'd2);

        // Saturation: read of busy r7 stalls indefinitely
        issue(4'd7, 4'd0, 4'd0, 1'b0, 8'h09, 32'h0, 32'h0);
        for (int i = 0; i < 65540; i++) tick();
        chk("sat_max", 32'(bus.stall_count), 32'hFFFF);
        tick();
        chk("sat_hold", 32'(bus.stall_count), 32'hFFFF);
        bus.id_valid = 1'b0;

        // Asynchronous reset with ex_valid=1 and pending=0x0020
        bus.wb_valid = 1'b1; bus.wb_reg = 4'd7;
        tick();
        bus.wb_valid = 1'b0;
        bus.ex_ready = 1'b0;
        issue(4'd0, 4'd0, 4'd5, 1'b1, 8'h0A, 32'h3, 32'h4);
        tick();
        bus.id_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
        chk("pre_rst_pend",  32'(bus.pending), 32'h20);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.ex_valid), 32'd0);
        chk("arst_pend",  32'(bus.pending), 32'h0);
        chk("arst_stall", 32'(bus.stall_count), 32'd0);
        chk("arst_op1",   bus.ex_op1, 32'h0);
        chk("arst_ready", 32'(bus.id_ready), 32'd1);
        tick();
        reset = 1'b0;
        bus.ex_ready = 1'b1;
        issue(4'd5, 4'd6, 4'd2, 1'b0, 8'h0B, 32'h66, 32'h77);
        tick();
        bus.id_valid = 1'b0;
        chk("post_rst_op1", bus.ex_op1, 32'h66);
        chk("post_rst_vld", 32'(bus.ex_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
